controller_poll_scheduler_m: RTL and testbench
==============================================

// Module: controller_poll_scheduler_m
// PURPOSE
//  Sequences controller_interface_m once per video frame. Each poll pulses its start input,
//  waits for the serial shift to finish, then captures both 8-bit controller words.
//  Holds CPU-readable button state plus sticky "newly pressed" edge registers.
//  Sits between the video timing (vsync) and the CPU bus decode for the controller I/O page.
// PARAMETERS
//  START_CYCLES   9  clk_1 cycles ci_start is held high per poll (1..255)
//  SETTLE_CYCLES  8  clk_1 cycles after ci_start falls before capture (1..255)
//  FRAME_DIV      1  poll on every FRAME_DIV-th vsync pulse (1..15)
// PORTS
//  clk_1        in   1  system/CPU clock; all state on rising edge
//  rst_n        in   1  asynchronous, active-low reset
//  vsync        in   1  one-cycle frame pulse, synchronous to clk_1
//  enable       in   1  1 = polling allowed; 0 = finish any poll in flight, then stay IDLE
//  ci_start     out  1  to controller_interface_m start
//  ci_data_1    in   8  controller_interface_m controller_1_data_out (1 = pressed)
//  ci_data_2    in   8  controller_interface_m controller_2_data_out
//  cpu_addr     in   2  0=buttons1 1=buttons2 2=pressed1 3=pressed2
//  cpu_rd       in   1  one-cycle read strobe
//  cpu_rdata    out  8  combinational mux of the addressed register
//  busy         out  1  high in START, SETTLE and CAPTURE
//  overrun      out  1  sticky: vsync arrived while a poll was already pending
//  irq_B        out  1  active-low new-press interrupt (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; ci_start=0; buttons1/2=0; pressed1/2=0; busy=0; overrun=0;
//   irq_B=1; frame count=0; pending=0.
//  Frame divider: each vsync increments a 4-bit count; at FRAME_DIV-1 it wraps to 0 and
//   raises a trigger. Divider runs regardless of state or enable.
//  pending: set by trigger when enable=1; cleared on IDLE->START.
//   Trigger while pending=1 sets overrun (cleared only by reset).
//  FSM:
//   IDLE    -> START when pending=1 and enable=1.
//   START   ci_start=1 for exactly START_CYCLES cycles, then -> SETTLE.
//   SETTLE  ci_start=0 for SETTLE_CYCLES cycles, then -> CAPTURE.
//   CAPTURE 1 cycle, then -> IDLE:
//    buttonsN <= ci_data_N; pressedN <= pressedN | (ci_data_N & ~buttonsN_old).
//  Latency: trigger -> buttons update = 1 + START_CYCLES + SETTLE_CYCLES + 1 cycles
//   (19 at defaults).
//  enable=0 mid-poll: the poll completes normally; no new poll starts.
//  Trigger during busy: sets pending (or overrun); poll runs right after return to IDLE.
//  Read side-effect: cpu_rd with addr 2/3 clears that pressed register next edge.
//   Same-cycle CAPTURE: result = new edges only (new edges win; old bits cleared).
//   Reads of addr 0/1 have no side-effect. cpu_rdata is valid the same cycle as cpu_rd.
// CONFIGURATION
//  CONTROLLER_POLL_SCHEDULER_IRQ_EN defined:
//   irq_B is driven low from the CAPTURE edge that makes (pressed1|pressed2) nonzero.
//   irq_B returns high once both pressed registers are zero.
//  Not defined: irq_B tied to 1; no interrupt logic is built. Port list is unchanged.
// STRUCTURE
//  Package controller_poll_pkg:
//   state_t enum {IDLE, START, SETTLE, CAPTURE}; ADDR_BTN1/ADDR_BTN2/ADDR_PRS1/ADDR_PRS2.
//  Sub-module poll_timer_m: 8-bit loadable down-counter with a done flag, shared by
//   START and SETTLE. The FSM, divider and registers live in the top.
// TESTING (bench pairs with controller_interface_m + two controller_m models)
//  1 Reset, buttons1=8'hFE, buttons2=8'h7F, one vsync -> ci_start high cycles 1-9,
//    buttons regs 8'hFE/8'h7F at cycle 19, pressed1=8'hFE, pressed2=8'h7F.
//  2 Read addr 2 -> rdata 8'hFE, pressed1=0 next cycle.
//    Next poll, same buttons -> pressed1 stays 0.
//  3 FRAME_DIV=3, 6 vsyncs -> exactly 2 polls. vsync on every cycle of a poll -> overrun=1,
//    one extra poll runs after IDLE.
//  4 enable dropped during SETTLE -> capture completes.
//    Later vsyncs produce no ci_start while enable=0.
//  5 cpu_rd addr 3 on the CAPTURE cycle, buttons2 8'h7F->8'hFF
//    -> pressed2=8'h80 (old bits cleared, new edge kept).
//  6 IRQ_EN defined: irq_B falls at the first capture, rises after reading addr 2 and 3.
//    Undefined: irq_B always 1. Assert rst_n low mid-START -> all outputs at reset values
//    immediately (async).

Source files
------------

// File: rtl/controller_poll_pkg.sv
// rtl/controller_poll_pkg.sv - shared state encoding and CPU register map for the poll scheduler
package controller_poll_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        SETTLE  = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] ADDR_BTN1 = 2'd0;
    localparam logic [1:0] ADDR_BTN2 = 2'd1;
    localparam logic [1:0] ADDR_PRS1 = 2'd2;
    localparam logic [1:0] ADDR_PRS2 = 2'd3;

endpackage

// File: rtl/controller_poll_scheduler_m_if.sv
// rtl/controller_poll_scheduler_m_if.sv - controller-interface and CPU read bus bundle
interface controller_poll_scheduler_m_if;

    logic       ci_start;
    logic [7:0] ci_data_1;
    logic [7:0] ci_data_2;
    logic [1:0] cpu_addr;
    logic       cpu_rd;
    logic [7:0] cpu_rdata;

    modport master (
        input  ci_start, cpu_rdata,
        output ci_data_1, ci_data_2, cpu_addr, cpu_rd
    );

    modport slave (
        output ci_start, cpu_rdata,
        input  ci_data_1, ci_data_2, cpu_addr, cpu_rd
    );

endinterface

// File: rtl/poll_timer_m.sv
// rtl/poll_timer_m.sv - 8-bit loadable down-counter; done is high on the last counted cycle
module poll_timer_m (
    input  logic       clk_1,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    // A load of N yields exactly N cycles in the following state.
    assign done = (count == 8'd1);

endmodule

// File: rtl/controller_poll_scheduler_m.sv
// rtl/controller_poll_scheduler_m.sv - per-frame controller poll FSM and CPU button registers (optional IRQ: CONTROLLER_POLL_SCHEDULER_IRQ_EN)
module controller_poll_scheduler_m
    import controller_poll_pkg::*;
#(
    parameter int START_CYCLES  = 9,
    parameter int SETTLE_CYCLES = 8,
    parameter int FRAME_DIV     = 1
) (
    input  logic                          clk_1,
    input  logic                          rst_n,
    input  logic                          vsync,
    input  logic                          enable,
    controller_poll_scheduler_m_if.slave  bus,
    output logic                          busy,
    output logic                          overrun,
    output logic                          irq_B
);

    state_t     state;
    logic [3:0] frame_cnt;
    logic       pending;
    logic       trigger;
    logic       launch;
    logic       capture;
    logic       timer_load;
    logic [7:0] timer_val;
    logic       timer_done;
    logic [7:0] buttons1, buttons2;
    logic [7:0] pressed1, pressed2;
    logic [7:0] pressed1_next, pressed2_next;

    assign trigger = vsync && (frame_cnt == 4'(FRAME_DIV - 1));
    // A trigger landing in IDLE launches at once so latency is 1 + START + SETTLE + 1.
    assign launch  = (state == IDLE) && enable && (pending || trigger);
    assign capture = (state == CAPTURE);

    assign timer_load = launch || ((state == START) && timer_done);
    assign timer_val  = launch ? 8'(START_CYCLES) : 8'(SETTLE_CYCLES);

    poll_timer_m u_timer (
        .clk_1    (clk_1),
        .rst_n    (rst_n),
        .load     (timer_load),
        .load_val (timer_val),
        .done     (timer_done)
    );

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (launch)     state <= START;
                START:   if (timer_done) state <= SETTLE;
                SETTLE:  if (timer_done) state <= CAPTURE;
                default:                 state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 4'd0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (vsync) frame_cnt <= trigger ? 4'd0 : frame_cnt + 4'd1;
            if (launch)                 pending <= 1'b0;
            else if (trigger && enable) pending <= 1'b1;
            if (trigger && pending) overrun <= 1'b1;
        end
    end

    // A clearing read coinciding with capture keeps only the freshly detected edges.
    always_comb begin
        pressed1_next = pressed1;
        pressed2_next = pressed2;
        if (bus.cpu_rd && (bus.cpu_addr == ADDR_PRS1)) pressed1_next = 8'd0;
        if (bus.cpu_rd && (bus.cpu_addr == ADDR_PRS2)) pressed2_next = 8'd0;
        if (capture) begin
            pressed1_next = pressed1_next | (bus.ci_data_1 & ~buttons1);
            pressed2_next = pressed2_next | (bus.ci_data_2 & ~buttons2);
        end
    end

    always_ff @(posedge clk_1 or negedge rst_n) begin
        if (!rst_n) begin
            buttons1 <= 8'd0;
            buttons2 <= 8'd0;
            pressed1 <= 8'd0;
            pressed2 <= 8'd0;
        end else begin
            if (capture) begin
                buttons1 <= bus.ci_data_1;
                buttons2 <= bus.ci_data_2;
            end
            pressed1 <= pressed1_next;
            pressed2 <= pressed2_next;
        end
    end

    always_comb begin
        case (bus.cpu_addr)
            ADDR_BTN1: bus.cpu_rdata = buttons1;
            ADDR_BTN2: bus.cpu_rdata = buttons2;
            ADDR_PRS1: bus.cpu_rdata = pressed1;
            default:   bus.cpu_rdata = pressed2;
        endcase
    end

    assign bus.ci_start = (state == START);
    assign busy         = (state != IDLE);

`ifdef CONTROLLER_POLL_SCHEDULER_IRQ_EN
    assign irq_B = ~(|(pressed1 | pressed2));
`else
    assign irq_B = 1'b1;
`endif

endmodule

// File: tb/tb_controller_poll_scheduler_m.sv
// tb/tb_controller_poll_scheduler_m.sv - directed self-checking bench for controller_poll_scheduler_m
module tb_controller_poll_scheduler_m;

`ifdef CONTROLLER_POLL_SCHEDULER_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic clk_1 = 1'b0;
    logic rst_n = 1'b0;
    logic vsync = 1'b0;
    logic enable = 1'b1;
    logic busy_m, ovr_m, irq_m;
    logic busy_d, ovr_d, irq_d;

    int n_checks = 0;
    int n_pass   = 0;
    int polls_m  = 0;
    int polls_d  = 0;
    logic prev_m = 1'b0;
    logic prev_d = 1'b0;
    int base_m, base_d;

    controller_poll_scheduler_m_if if_m ();
    controller_poll_scheduler_m_if if_d ();

    controller_poll_scheduler_m u_dut (
        .clk_1   (clk_1),
        .rst_n   (rst_n),
        .vsync   (vsync),
        .enable  (enable),
        .bus     (if_m),
        .busy    (busy_m),
        .overrun (ovr_m),
        .irq_B   (irq_m)
    );

    controller_poll_scheduler_m #(.FRAME_DIV(3)) u_dut_div3 (
        .clk_1   (clk_1),
        .rst_n   (rst_n),
        .vsync   (vsync),
        .enable  (enable),
        .bus     (if_d),
        .busy    (busy_d),
        .overrun (ovr_d),
        .irq_B   (irq_d)
    );

    always #5 clk_1 = ~clk_1;

    always @(posedge clk_1) begin
        prev_m <= if_m.ci_start;
        prev_d <= if_d.ci_start;
        if (if_m.ci_start && !prev_m) polls_m <= polls_m + 1;
        if (if_d.ci_start && !prev_d) polls_d <= polls_d + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk_1);
        #2;
    endtask

    task automatic peek(input string tag, input logic [1:0] addr, input logic [7:0] exp);
        if_m.cpu_addr = addr;
        #1;
        check(tag, {24'd0, if_m.cpu_rdata}, {24'd0, exp});
    endtask

    // Leaves the bench in cycle 1 of the poll (vsync was in cycle 0).
    task automatic pulse_vsync();
        vsync = 1'b1;
        step();
        vsync = 1'b0;
    endtask

    initial begin
        if_m.ci_data_1 = 8'h00; if_m.ci_data_2 = 8'h00;
        if_m.cpu_addr  = 2'd0;  if_m.cpu_rd    = 1'b0;
        if_d.ci_data_1 = 8'h00; if_d.ci_data_2 = 8'h00;
        if_d.cpu_addr  = 2'd0;  if_d.cpu_rd    = 1'b0;

        repeat (3) step();
        check("rst_ci_start", {31'd0, if_m.ci_start}, 32'd0);
        check("rst_busy",     {31'd0, busy_m},        32'd0);
        check("rst_overrun",  {31'd0, ovr_m},         32'd0);
        check("rst_irq",      {31'd0, irq_m},         32'd1);
        peek("rst_btn1", 2'd0, 8'h00);
        peek("rst_prs2", 2'd3, 8'h00);
        rst_n = 1'b1;
        step();

        // Poll 1: timing of ci_start and capture latency.
        if_m.ci_data_1 = 8'hFE; if_m.ci_data_2 = 8'h7F;
        pulse_vsync();
        check("p1_start_c1", {31'd0, if_m.ci_start}, 32'd1);
        repeat (8) step();
        check("p1_start_c9", {31'd0, if_m.ci_start}, 32'd1);
        step();
        check("p1_start_c10", {31'd0, if_m.ci_start}, 32'd0);
        check("p1_busy_c10",  {31'd0, busy_m},        32'd1);
        repeat (8) step();
        check("p1_busy_c18", {31'd0, busy_m}, 32'd1);
        peek("p1_btn1_c18", 2'd0, 8'h00);
        step();
        check("p1_busy_c19", {31'd0, busy_m}, 32'd0);
        peek("p1_btn1", 2'd0, 8'hFE);
        peek("p1_btn2", 2'd1, 8'h7F);
        peek("p1_prs1", 2'd2, 8'hFE);
        peek("p1_prs2", 2'd3, 8'h7F);
        check("p1_irq", {31'd0, irq_m}, IRQ_ON ? 32'd0 : 32'd1);

        // Clearing reads and a repeat poll with unchanged buttons.
        step();
        if_m.cpu_addr = 2'd2; if_m.cpu_rd = 1'b1;
        #1;
        check("rd2_rdata", {24'd0, if_m.cpu_rdata}, 32'h000000FE);
        step();
        if_m.cpu_rd = 1'b0;
        peek("rd2_cleared", 2'd2, 8'h00);
        check("rd2_irq", {31'd0, irq_m}, IRQ_ON ? 32'd0 : 32'd1);
        pulse_vsync();
        repeat (19) step();
        peek("p2_prs1", 2'd2, 8'h00);
        peek("p2_prs2", 2'd3, 8'h7F);
        if_m.cpu_rd = 1'b1;
        step();
        if_m.cpu_rd = 1'b0;
        peek("rd3_cleared", 2'd3, 8'h00);
        check("rd3_irq", {31'd0, irq_m}, 32'd1);

        // Frame divider: six spaced vsyncs.
        base_m = polls_m; base_d = polls_d;
        repeat (6) begin
            pulse_vsync();
            repeat (24) step();
        end
        check("div1_polls", polls_m - base_m, 32'd6);
        check("div3_polls", polls_d - base_d, 32'd2);

        // vsync on every cycle of a poll.
        check("ovr_before", {31'd0, ovr_m}, 32'd0);
        base_m = polls_m;
        vsync = 1'b1;
        repeat (19) step();
        vsync = 1'b0;
        repeat (45) step();
        check("ovr_after", {31'd0, ovr_m}, 32'd1);
        check("ovr_polls", polls_m - base_m, 32'd2);

        // enable dropped during SETTLE.
        if_m.ci_data_1 = 8'h0F;
        pulse_vsync();
        repeat (11) step();
        check("en_busy_c12", {31'd0, busy_m}, 32'd1);
        enable = 1'b0;
        repeat (7) step();
        peek("en_btn1", 2'd0, 8'h0F);
        peek("en_prs1", 2'd2, 8'h01);
        base_m = polls_m;
        repeat (3) begin
            pulse_vsync();
            repeat (24) step();
        end
        enable = 1'b1;
        repeat (5) step();
        check("en_no_polls", polls_m - base_m, 32'd0);
        check("en_idle",     {31'd0, busy_m},  32'd0);

        // Clearing read on the CAPTURE cycle.
        if_m.ci_data_2 = 8'h00;
        pulse_vsync();
        repeat (24) step();
        if_m.ci_data_2 = 8'h7F;
        pulse_vsync();
        repeat (24) step();
        peek("cap_prs2_pre", 2'd3, 8'h7F);
        if_m.ci_data_2 = 8'hFF;
        pulse_vsync();
        repeat (17) step();
        if_m.cpu_addr = 2'd3; if_m.cpu_rd = 1'b1;
        #1;
        check("cap_rdata", {24'd0, if_m.cpu_rdata}, 32'h0000007F);
        check("cap_busy",  {31'd0, busy_m},         32'd1);
        step();
        if_m.cpu_rd = 1'b0;
        peek("cap_prs2", 2'd3, 8'h80);
        check("cap_irq", {31'd0, irq_m}, IRQ_ON ? 32'd0 : 32'd1);

        // Asynchronous reset in the middle of START.
        pulse_vsync();
        repeat (2) step();
        check("ar_start", {31'd0, if_m.ci_start}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_ci_start", {31'd0, if_m.ci_start}, 32'd0);
        check("ar_busy",     {31'd0, busy_m},        32'd0);
        check("ar_overrun",  {31'd0, ovr_m},         32'd0);
        check("ar_irq",      {31'd0, irq_m},         32'd1);
        peek("ar_btn1", 2'd0, 8'h00);
        peek("ar_prs2", 2'd3, 8'h00);
        repeat (2) step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
